// File: rtl/sram_fifo_wrapper_if.sv
// FIFO user-side bundle for sram_fifo_wrapper: push/pop handshake, status and head data.
interface sram_fifo_wrapper_if #(
    parameter int DWIDTH = 64,
    parameter int DEPTH  = 4096
);
    localparam int AWIDTH = $clog2(DEPTH);

    logic              fifo_rst;
    logic              fifo_wr_en;
    logic              fifo_rd_en;
    logic [DWIDTH-1:0] fifo_wdata;
    logic              fifo_empty;
    logic              fifo_full;
    logic [AWIDTH:0]   fifo_numel;
    logic [DWIDTH-1:0] fifo_rdata;

    modport master (
        output fifo_rst, fifo_wr_en, fifo_rd_en, fifo_wdata,
        input  fifo_empty, fifo_full, fifo_numel, fifo_rdata
    );

    modport slave (
        input  fifo_rst, fifo_wr_en, fifo_rd_en, fifo_wdata,
        output fifo_empty, fifo_full, fifo_numel, fifo_rdata
    );
endinterface

// File: rtl/sram_fifo_wrapper.sv
// First-word-fall-through FIFO built around an external true dual-port synchronous SRAM.
// Port A only writes pushed words; port B continuously prefetches the head word so a pop
// exposes the next word on the following cycle.
module sram_fifo_wrapper #(
    parameter int DWIDTH = 64,
    parameter int DEPTH  = 4096,
    localparam int AWIDTH = $clog2(DEPTH),
    localparam int WMASK  = DWIDTH / 8
) (
    input  logic              clk,
    input  logic              rst,
    sram_fifo_wrapper_if.slave fifo,
    output logic              ce_a,
    output logic              we_a,
    output logic [AWIDTH-1:0] addr_a,
    output logic [WMASK-1:0]  wmask_a,
    output logic [DWIDTH-1:0] wdata_a,
    output logic              ce_b,
    output logic              we_b,
    output logic [AWIDTH-1:0] addr_b,
    output logic [WMASK-1:0]  wmask_b,
    output logic [DWIDTH-1:0] wdata_b,
    input  logic [DWIDTH-1:0] rdata_a,
    input  logic [DWIDTH-1:0] rdata_b
);
    localparam logic [AWIDTH-1:0] PTR_ONE   = AWIDTH'(1);
    localparam logic [AWIDTH:0]   NUMEL_ONE = (AWIDTH + 1)'(1);
    localparam logic [AWIDTH:0]   NUMEL_MAX = (AWIDTH + 1)'(DEPTH);

    logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [AWIDTH:0]   numel_q, numel_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              rdata_clr_q, rdata_clr_d;
    logic              clr;
    logic              push_ok;
    logic              pop_ok;
    logic              prefetch;
    logic              unused_rdata_a;

    // Next-state: accept decisions, pointer/count updates, and head visibility.
    // A word written at an edge is not readable by a same-edge read (old data is
    // returned), so the head only counts as presented when it was already stored
    // before the edge that reads it: empty_d excludes a word pushed this cycle.
    always_comb begin
        clr      = rst | fifo.fifo_rst;
        push_ok  = fifo.fifo_wr_en & ~full_q;
        pop_ok   = fifo.fifo_rd_en & ~empty_q;
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        numel_d  = numel_q;
        if (push_ok && !pop_ok) begin
            numel_d = numel_q + NUMEL_ONE;
        end else if (pop_ok && !push_ok) begin
            numel_d = numel_q - NUMEL_ONE;
        end
        full_d      = (numel_d == NUMEL_MAX);
        empty_d     = (numel_d == (push_ok ? NUMEL_ONE : '0));
        prefetch    = ~clr & ~empty_d;
        rdata_clr_d = rdata_clr_q & ~prefetch;
    end

    // State registers; rst and fifo_rst both clear the FIFO bookkeeping.
    always_ff @(posedge clk) begin
        if (rst || fifo.fifo_rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            numel_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            rdata_clr_q <= 1'b1;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            numel_q     <= numel_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            rdata_clr_q <= rdata_clr_d;
        end
    end

    // Port A writes the accepted push; a clear in the same cycle suppresses it.
    assign ce_a    = push_ok & ~clr;
    assign we_a    = ce_a;
    assign addr_a  = wr_ptr_q;
    assign wmask_a = ce_a ? {WMASK{1'b1}} : '0;
    assign wdata_a = ce_a ? fifo.fifo_wdata : '0;

    // Port B reads the post-update head address whenever a stored head exists.
    assign ce_b    = prefetch;
    assign we_b    = 1'b0;
    assign addr_b  = rd_ptr_d;
    assign wmask_b = '0;
    assign wdata_b = '0;

    // Head data comes straight from the SRAM output latch; forced to zero after a
    // clear until the first prefetch lands so stale data never leaks out.
    assign fifo.fifo_rdata = rdata_clr_q ? '0 : rdata_b;
    assign fifo.fifo_empty = empty_q;
    assign fifo.fifo_full  = full_q;
    assign fifo.fifo_numel = numel_q;

    assign unused_rdata_a = ^rdata_a;
endmodule

// File: tb/tb_sram_fifo_wrapper.sv
// Scoreboard bench for sram_fifo_wrapper with a behavioural dual-port SRAM.
module tb_sram_fifo_wrapper;
    localparam int DWIDTH = 64;
    localparam int DEPTH  = 4096;
    localparam int AWIDTH = $clog2(DEPTH);
    localparam int WMASK  = DWIDTH / 8;

    typedef struct {
        logic [DWIDTH-1:0] data;
        int                stamp;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic              ce_a, we_a, ce_b, we_b;
    logic [AWIDTH-1:0] addr_a, addr_b;
    logic [WMASK-1:0]  wmask_a, wmask_b;
    logic [DWIDTH-1:0] wdata_a, wdata_b;
    logic [DWIDTH-1:0] rdata_a = '0;
    logic [DWIDTH-1:0] rdata_b = '0;
    logic [DWIDTH-1:0] mem [DEPTH];

    ent_t ref_q[$];
    int   cyc     = 0;
    int   wptr    = 0;
    int   n_total = 0;
    int   n_pass  = 0;

    sram_fifo_wrapper_if #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) fif ();

    sram_fifo_wrapper #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .fifo    (fif),
        .ce_a    (ce_a),
        .we_a    (we_a),
        .addr_a  (addr_a),
        .wmask_a (wmask_a),
        .wdata_a (wdata_a),
        .ce_b    (ce_b),
        .we_b    (we_b),
        .addr_b  (addr_b),
        .wmask_b (wmask_b),
        .wdata_b (wdata_b),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b)
    );

    initial forever #5 clk = ~clk;

    // Synchronous true dual-port SRAM: reads return pre-edge contents.
    always @(posedge clk) begin
        if (ce_a && we_a) begin
            for (int i = 0; i < WMASK; i++)
                if (wmask_a[i]) mem[addr_a][i*8 +: 8] <= wdata_a[i*8 +: 8];
        end else if (ce_a) begin
            rdata_a <= mem[addr_a];
        end
        if (ce_b && we_b) begin
            for (int i = 0; i < WMASK; i++)
                if (wmask_b[i]) mem[addr_b][i*8 +: 8] <= wdata_b[i*8 +: 8];
        end else if (ce_b) begin
            rdata_b <= mem[addr_b];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: queue of stored words, updated at each edge.
    initial forever begin
        bit push_ok, pop_ok;
        @(posedge clk);
        cyc++;
        if (rst || fif.fifo_rst) begin
            ref_q.delete();
            wptr = 0;
        end else begin
            push_ok = fif.fifo_wr_en && (ref_q.size() < DEPTH);
            pop_ok  = fif.fifo_rd_en && !fif.fifo_empty;
            if (pop_ok && ref_q.size() > 0) void'(ref_q.pop_front());
            if (push_ok) begin
                ref_q.push_back('{data: fif.fifo_wdata, stamp: cyc});
                wptr = (wptr + 1) % DEPTH;
            end
        end
    end

    // Monitor: compares DUT outputs against the model away from the active edge.
    initial forever begin
        int   sz;
        logic exp_ce;
        @(negedge clk);
        sz = ref_q.size();
        chk("numel", 64'(fif.fifo_numel), 64'(sz));
        chk("full", 64'(fif.fifo_full), 64'(sz == DEPTH));
        if (sz == 0) chk("empty_when_none", 64'(fif.fifo_empty), 64'(1));
        else if (cyc - ref_q[0].stamp >= 2) chk("head_presented", 64'(fif.fifo_empty), 64'(0));
        if (!fif.fifo_empty && sz > 0) chk("rdata_head", fif.fifo_rdata, ref_q[0].data);
        exp_ce = fif.fifo_wr_en && (sz < DEPTH) && !rst && !fif.fifo_rst;
        chk("ce_a", 64'(ce_a), 64'(exp_ce));
        chk("we_a", 64'(we_a), 64'(exp_ce));
        if (exp_ce) begin
            chk("addr_a", 64'(addr_a), 64'(wptr));
            chk("wdata_a", wdata_a, fif.fifo_wdata);
            chk("wmask_a", 64'(wmask_a), 64'({WMASK{1'b1}}));
        end
        chk("portb_static", {62'd0, we_b, |wmask_b} | 64'(wdata_b != '0), 64'(0));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_pop, guard;
        fif.fifo_rst   = 1'b0;
        fif.fifo_wr_en = 1'b0;
        fif.fifo_rd_en = 1'b0;
        fif.fifo_wdata = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_rdata", fif.fifo_rdata, 64'(0));
        chk("reset_ce_b", 64'(ce_b), 64'(0));
        chk("reset_empty", 64'(fif.fifo_empty), 64'(1));

        // Fill well past capacity, one push every other cycle.
        for (int j = 0; j < 16384; j++) begin
            fif.fifo_wr_en = 1'b1;
            fif.fifo_wdata = 64'(j + 1);
            tick();
            fif.fifo_wr_en = 1'b0;
            tick();
        end
        chk("fill_full", 64'(fif.fifo_full), 64'(1));
        chk("fill_numel", 64'(fif.fifo_numel), 64'(DEPTH));

        // Drain, one pop every other cycle; the monitor checks each head.
        n_pop = 0;
        guard = 0;
        while (!fif.fifo_empty && guard < 3 * DEPTH) begin
            chk("drain_head_order", fif.fifo_rdata, 64'(n_pop + 1));
            fif.fifo_rd_en = 1'b1;
            tick();
            fif.fifo_rd_en = 1'b0;
            n_pop++;
            tick();
            guard++;
        end
        chk("drain_count", 64'(n_pop), 64'(DEPTH));
        chk("drain_empty", 64'(fif.fifo_empty), 64'(1));
        chk("drain_numel", 64'(fif.fifo_numel), 64'(0));

        // Single push into empty FIFO must surface within two edges.
        fif.fifo_wr_en = 1'b1;
        fif.fifo_wdata = 64'hA5;
        tick();
        fif.fifo_wr_en = 1'b0;
        tick();
        tick();
        chk("latency_empty", 64'(fif.fifo_empty), 64'(0));
        chk("latency_rdata", fif.fifo_rdata, 64'hA5);
        fif.fifo_rd_en = 1'b1;
        tick();
        fif.fifo_rd_en = 1'b0;
        tick();

        // Streaming: preload four words, then push+pop every cycle across wraps.
        for (int j = 0; j < 4; j++) begin
            fif.fifo_wr_en = 1'b1;
            fif.fifo_wdata = {$urandom, $urandom};
            tick();
        end
        fif.fifo_wr_en = 1'b0;
        tick();
        tick();
        for (int j = 0; j < 10000; j++) begin
            fif.fifo_wr_en = 1'b1;
            fif.fifo_rd_en = 1'b1;
            fif.fifo_wdata = {$urandom, $urandom};
            tick();
        end
        fif.fifo_wr_en = 1'b0;
        fif.fifo_rd_en = 1'b0;
        chk("stream_numel", 64'(fif.fifo_numel), 64'(4));

        // Random traffic with occasional FIFO clears.
        for (int j = 0; j < 4000; j++) begin
            fif.fifo_wr_en = ($urandom_range(0, 9) < 6);
            fif.fifo_rd_en = ($urandom_range(0, 9) < 5);
            fif.fifo_rst   = ($urandom_range(0, 255) == 0);
            fif.fifo_wdata = {$urandom, $urandom};
            tick();
        end
        fif.fifo_wr_en = 1'b0;
        fif.fifo_rd_en = 1'b0;
        fif.fifo_rst   = 1'b1;
        tick();
        fif.fifo_rst   = 1'b0;

        // Fill to 100 then clear with a competing push and pop.
        for (int j = 0; j < 100; j++) begin
            fif.fifo_wr_en = 1'b1;
            fif.fifo_wdata = {$urandom, $urandom};
            tick();
        end
        fif.fifo_rd_en = 1'b1;
        fif.fifo_rst   = 1'b1;
        tick();
        fif.fifo_wr_en = 1'b0;
        fif.fifo_rd_en = 1'b0;
        fif.fifo_rst   = 1'b0;
        chk("clr_numel", 64'(fif.fifo_numel), 64'(0));
        chk("clr_empty", 64'(fif.fifo_empty), 64'(1));
        chk("clr_full", 64'(fif.fifo_full), 64'(0));
        fif.fifo_wr_en = 1'b1;
        fif.fifo_wdata = 64'h1;
        tick();
        fif.fifo_wr_en = 1'b0;
        tick();
        tick();
        chk("clr_push_rdata", fif.fifo_rdata, 64'h1);
        chk("clr_push_empty", 64'(fif.fifo_empty), 64'(0));

        // Reset right after a push discards the in-flight prefetch.
        fif.fifo_wr_en = 1'b1;
        fif.fifo_wdata = 64'h77;
        tick();
        fif.fifo_wr_en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_empty", 64'(fif.fifo_empty), 64'(1));
        chk("midrst_rdata", fif.fifo_rdata, 64'(0));
        fif.fifo_wr_en = 1'b1;
        fif.fifo_wdata = 64'h88;
        tick();
        fif.fifo_wr_en = 1'b0;
        tick();
        tick();
        chk("midrst_head", fif.fifo_rdata, 64'h88);
        chk("midrst_numel", 64'(fif.fifo_numel), 64'(1));
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/sram_fifo_wrapper.md
SRAM_FIFO_WRAPPER -- requirements
Module: sram_fifo_wrapper

Interface
REQ-001 Parameter DWIDTH, default 64, FIFO/SRAM word width in bits.
REQ-002 Parameter DEPTH, default 4096, FIFO capacity in words; power of two.
REQ-003 Derived AWIDTH = clog2(DEPTH); derived WMASK = DWIDTH/8 byte-lane count.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 fifo_rst  in  1  synchronous active-high FIFO clear.
REQ-008 fifo_wr_en  in  1  push request.
REQ-009 fifo_rd_en  in  1  pop request.
REQ-010 fifo_wdata  in  DWIDTH  push data.
REQ-011 fifo_empty  out  1  no readable word.
REQ-012 fifo_full  out  1  DEPTH words held.
REQ-013 fifo_numel  out  AWIDTH+1  words held, range 0..DEPTH.
REQ-014 fifo_rdata  out  DWIDTH  head word, first-word-fall-through.
REQ-015 ce_a, we_a  out  1 each  SRAM port-A chip enable and write enable.
REQ-016 addr_a  out  AWIDTH  SRAM port-A address.
REQ-017 wmask_a  out  WMASK  SRAM port-A byte write mask.
REQ-018 wdata_a  out  DWIDTH  SRAM port-A write data.
REQ-019 ce_b, we_b, addr_b, wmask_b, wdata_b  out  port-B equivalents, same widths as port A.
REQ-020 rdata_a, rdata_b  in  DWIDTH  SRAM read data.

Function
REQ-021 External SRAM (event_sram) contract: true dual-port, DEPTH x DWIDTH, synchronous; with ce=1 and we=1 it writes the bytes selected by wmask at the edge; with ce=1 and we=0, rdata is valid after the next edge and holds until the next read.
REQ-022 SRAM contract, same-address write on one port and read on the other in the same cycle: the read returns the old data.
REQ-023 Port A is write-only: ce_a=we_a=1, wmask_a all ones, addr_a=wr_ptr, wdata_a=fifo_wdata only in a cycle where a push is accepted; otherwise ce_a=we_a=0.
REQ-024 Port B is read-only: we_b=0, wmask_b=0, wdata_b=0 always; ce_b, addr_b prefetch the head word.
REQ-025 A push is accepted iff fifo_wr_en=1 and fifo_full=0; on accept, the word is stored at wr_ptr and wr_ptr increments modulo DEPTH.
REQ-026 A push while full is dropped silently and changes no state or output.
REQ-027 A pop is accepted iff fifo_rd_en=1 and fifo_empty=0; on accept, rd_ptr increments modulo DEPTH and the next word is presented.
REQ-028 A pop while empty is ignored.
REQ-029 fifo_rdata equals the oldest unpopped word whenever fifo_empty=0.
REQ-030 fifo_rdata is don't-care (holds last value) when fifo_empty=1.
REQ-031 fifo_numel +1 on accepted push only; -1 on accepted pop only; unchanged when both are accepted in one cycle.
REQ-032 fifo_full = (fifo_numel == DEPTH), registered.
REQ-033 Latency: a word pushed into an empty FIFO makes fifo_empty=0 and appears at fifo_rdata no later than 2 edges after the accept edge.
REQ-034 fifo_empty=1 until the head word is actually presented, even while fifo_numel>0 during that latency.
REQ-035 Sustained throughput: one push and one pop per cycle.
REQ-036 Back-to-back pops present each successive word on the cycle after each pop, with no bubbles while words remain readable.
REQ-037 Wrap-around: pointers wrap DEPTH-1 -> 0 with no data loss or reordering.
REQ-038 Simultaneous push and pop with one readable word: the pop is taken and the new word becomes the head via the latency path of REQ-033.
REQ-039 Simultaneous push and pop when full: the pop is accepted and the push is rejected.

Reset
REQ-040 rst=1 at an edge clears the FIFO: wr_ptr=0, rd_ptr=0, fifo_numel=0, fifo_empty=1, fifo_full=0, fifo_rdata=0, ce_a=we_a=ce_b=0.
REQ-041 fifo_rst=1 at an edge has the same effect as rst, overriding any same-cycle push or pop; SRAM contents are not cleared.
REQ-042 Reset asserted mid-transfer discards in-flight prefetch; the first push after release is the next head.

Verification
REQ-043 Reset, then idle -> fifo_empty=1, fifo_full=0, fifo_numel=0, ce_a=0.
REQ-044 Push 1..16384 (value j+1), one push every other cycle -> fifo_full=1 after the 4096th push; fifo_numel=4096; pushes 4097..16384 dropped.
REQ-045 Then pop while !fifo_empty, one pop every other cycle, checking fifo_rdata before each pop -> values 1..4096 in order; then fifo_empty=1 and fifo_numel=0.
REQ-046 Push 0xA5 into an empty FIFO -> fifo_rdata=0xA5 and fifo_empty=0 within 2 edges.
REQ-047 Push and pop every cycle for 10000 cycles with random data -> in-order data across pointer wrap; fifo_numel constant.
REQ-048 Fill to 100 words, then fifo_rst=1 for one cycle -> fifo_numel=0, fifo_empty=1, fifo_full=0; a subsequent push of 0x1 reads back 0x1.
